// File: rtl/uart_irq_sequencer_pkg.sv
// Shared types and register field positions for the UART interrupt sequencer.
package uart_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_NONE = 2'd0,
        IRQ_RX   = 2'd1,
        IRQ_TX   = 2'd2,
        IRQ_ERR  = 2'd3
    } irq_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE,
        HOLDOFF
    } state_t;

    localparam int CTRL_RX_EN    = 0;
    localparam int CTRL_TX_EN    = 1;
    localparam int CTRL_ERR_EN   = 2;

    localparam int STAT_RX_FULL  = 0;
    localparam int STAT_OERR     = 1;
    localparam int STAT_PERR     = 2;
    localparam int STAT_FERR     = 3;
    localparam int STAT_TX_EMPTY = 5;

endpackage

// File: rtl/uart_irq_sequencer_if.sv
// CPU-facing interrupt handshake: request/ID/busy out, ack/done back in.
interface uart_irq_sequencer_if;
    import uart_irq_pkg::*;

    logic    irq;
    irq_id_t irq_id;
    logic    busy;
    logic    irq_ack;
    logic    irq_done;

    modport master (output irq, irq_id, busy, input irq_ack, irq_done);
    modport slave  (input irq, irq_id, busy, output irq_ack, irq_done);
endinterface

// File: rtl/uart_irq_sequencer_pend.sv
// One interrupt source: condition register, rising-edge detect and pending latch.
module uart_irq_pend (
    input  logic clk,
    input  logic reset_n,
    input  logic cond,
    input  logic clr,
    output logic pending
);
    logic cond_p0;
    logic cond_p1;
    logic rise;

    assign rise = cond_p0 & ~cond_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_p0 <= 1'b0;
            cond_p1 <= 1'b0;
            pending <= 1'b0;
        end else begin
            cond_p0 <= cond;
            cond_p1 <= cond_p0;
            // A fresh edge in the same cycle as a clear wins, so it is re-requested.
            pending <= (pending & ~clr) | rise;
        end
    end
endmodule

// File: rtl/uart_irq_sequencer.sv
// UART interrupt sequencer: one request at a time with ack/done handshake and hold-off.
// Optional per-source service counters are built when UART_IRQ_CNT_EN is defined.
module uart_irq_sequencer
    import uart_irq_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             control_reg,
    input  logic [7:0]             status_reg,
    input  logic                   dis_int,
    uart_irq_sequencer_if.master   bus
`ifdef UART_IRQ_CNT_EN
    ,
    output logic [CNT_W-1:0]       rx_cnt,
    output logic [CNT_W-1:0]       tx_cnt,
    output logic [CNT_W-1:0]       err_cnt
`endif
);
    localparam int HW = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

    // Source vectors are ordered {ERR, TX, RX}.
    logic [2:0] cond;
    logic [2:0] pend;
    logic [2:0] enable;
    logic [2:0] elig;
    logic [2:0] clr;

    state_t          state, state_nxt;
    irq_id_t         irq_id_r, irq_id_nxt;
    logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
    logic            cur_elig;
    logic            ack_take;

    logic unused_bits;
    assign unused_bits = ^{control_reg[7:3], status_reg[7:6], status_reg[4]};

    assign cond = {status_reg[STAT_OERR] | status_reg[STAT_PERR] | status_reg[STAT_FERR],
                   status_reg[STAT_TX_EMPTY],
                   status_reg[STAT_RX_FULL]};

    assign enable = {control_reg[CTRL_ERR_EN] & ~dis_int,
                     control_reg[CTRL_TX_EN],
                     control_reg[CTRL_RX_EN]};

    assign elig = pend & enable;

    for (genvar g = 0; g < 3; g++) begin : g_src
        uart_irq_pend u_pend (
            .clk     (clk),
            .reset_n (reset_n),
            .cond    (cond[g]),
            .clr     (clr[g]),
            .pending (pend[g])
        );
    end

    always_comb begin
        cur_elig = 1'b0;
        case (irq_id_r)
            IRQ_RX:  cur_elig = elig[0];
            IRQ_TX:  cur_elig = elig[1];
            IRQ_ERR: cur_elig = elig[2];
            default: cur_elig = 1'b0;
        endcase
    end

    assign ack_take = (state == ASSERT) && bus.irq_ack;

    always_comb begin
        state_nxt    = state;
        irq_id_nxt   = irq_id_r;
        hold_cnt_nxt = hold_cnt;
        clr          = 3'b000;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt = ASSERT;
                    if (elig[2])      irq_id_nxt = IRQ_ERR;
                    else if (elig[0]) irq_id_nxt = IRQ_RX;
                    else              irq_id_nxt = IRQ_TX;
                end
            end
            ASSERT: begin
                // An ack seen alongside a loss of eligibility still counts: irq was visible.
                if (bus.irq_ack) begin
                    state_nxt = SERVICE;
                    case (irq_id_r)
                        IRQ_RX:  clr[0] = 1'b1;
                        IRQ_TX:  clr[1] = 1'b1;
                        IRQ_ERR: clr[2] = 1'b1;
                        default: clr    = 3'b000;
                    endcase
                end else if (!cur_elig) begin
                    state_nxt  = IDLE;
                    irq_id_nxt = IRQ_NONE;
                end
            end
            SERVICE: begin
                if (bus.irq_done) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        state_nxt  = IDLE;
                        irq_id_nxt = IRQ_NONE;
                    end else begin
                        state_nxt    = HOLDOFF;
                        hold_cnt_nxt = HW'(HOLDOFF_CYCLES);
                    end
                end
            end
            HOLDOFF: begin
                hold_cnt_nxt = hold_cnt - 1'b1;
                if (hold_cnt <= HW'(1)) begin
                    state_nxt    = IDLE;
                    irq_id_nxt   = IRQ_NONE;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                irq_id_nxt = IRQ_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            irq_id_r <= IRQ_NONE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            irq_id_r <= irq_id_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    assign bus.irq    = (state == ASSERT);
    assign bus.irq_id = irq_id_r;
    assign bus.busy   = (state != IDLE);

`ifdef UART_IRQ_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            err_cnt <= '0;
        end else if (ack_take) begin
            case (irq_id_r)
                IRQ_RX:  rx_cnt  <= sat_inc(rx_cnt);
                IRQ_TX:  tx_cnt  <= sat_inc(tx_cnt);
                IRQ_ERR: err_cnt <= sat_inc(err_cnt);
                default: ;
            endcase
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ack_take;
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_uart_irq_sequencer.sv
// Directed + randomized bench for uart_irq_sequencer with a behavioural service model.
module tb_uart_irq_sequencer;
    localparam int HOLD  = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] control_reg;
    logic [7:0] status_reg;
    logic       dis_int;

    uart_irq_sequencer_if bus ();

`ifdef UART_IRQ_CNT_EN
    logic [CW-1:0] rx_cnt, tx_cnt, err_cnt;
`endif

    uart_irq_sequencer #(.HOLDOFF_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .control_reg (control_reg),
        .status_reg  (status_reg),
        .dis_int     (dis_int),
        .bus         (bus.master)
`ifdef UART_IRQ_CNT_EN
        ,
        .rx_cnt      (rx_cnt),
        .tx_cnt      (tx_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 requesting, 2 being serviced, 3 cooling down.
    // Source index = irq id - 1 (RX 0, TX 1, ERR 2).
    int m_phase, m_id, m_hold;
    int m_seen[3], m_prev[3], m_pend[3], m_cnt[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_id = 0; m_hold = 0;
        for (int i = 0; i < 3; i++) begin
            m_seen[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        int c[3], en[3], el[3], clear;
        if (!reset_n) begin
            model_reset();
            return;
        end
        c[0]  = int'(status_reg[0]);
        c[1]  = int'(status_reg[5]);
        c[2]  = int'(status_reg[1] | status_reg[2] | status_reg[3]);
        en[0] = int'(control_reg[0]);
        en[1] = int'(control_reg[1]);
        en[2] = int'(control_reg[2] & ~dis_int);
        for (int i = 0; i < 3; i++) el[i] = m_pend[i] & en[i];
        clear = -1;
        if (m_phase == 0) begin
            if (el[0] + el[1] + el[2] > 0) begin
                m_phase = 1;
                m_id = el[2] ? 3 : (el[0] ? 1 : 2);
            end
        end else if (m_phase == 1) begin
            if (bus.irq_ack === 1'b1) begin
                clear = m_id - 1;
                if (m_cnt[clear] < CMAX) m_cnt[clear]++;
                m_phase = 2;
            end else if (el[m_id - 1] == 0) begin
                m_phase = 0; m_id = 0;
            end
        end else if (m_phase == 2) begin
            if (bus.irq_done === 1'b1) begin
                if (HOLD == 0) begin m_phase = 0; m_id = 0; end
                else begin m_phase = 3; m_hold = HOLD; end
            end
        end else begin
            m_hold--;
            if (m_hold == 0) begin m_phase = 0; m_id = 0; end
        end
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = ((m_pend[i] != 0) && clear != i) || (m_seen[i] != 0 && m_prev[i] == 0) ? 1 : 0;
            m_prev[i] = m_seen[i];
            m_seen[i] = c[i];
        end
    endtask

    task automatic check_all();
        chk("irq", 32'(bus.irq), 32'(m_phase == 1));
        chk("irq_id", 32'(bus.irq_id), 32'(m_id));
        chk("busy", 32'(bus.busy), 32'(m_phase != 0));
`ifdef UART_IRQ_CNT_EN
        chk("rx_cnt", 32'(rx_cnt), 32'(m_cnt[0]));
        chk("tx_cnt", 32'(tx_cnt), 32'(m_cnt[1]));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt[2]));
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (bus.irq !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("wait_irq_timeout", 32'(bus.irq), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 60) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic ack_done();
        bus.irq_ack = 1'b1;  step(); bus.irq_ack = 1'b0;
        bus.irq_done = 1'b1; step(); bus.irq_done = 1'b0;
        wait_idle();
    endtask

    int n;
    int ids[3];

    initial begin
        reset_n = 1'b0; control_reg = 8'h00; status_reg = 8'h00; dis_int = 1'b0;
        bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
        model_reset();
        step(); step();
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_id", 32'(bus.irq_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        step();

        // 1: single RX request, latency and hold-off length
        control_reg = 8'h01;
        status_reg[0] = 1'b1;
        step(); chk("t1_lat1", 32'(bus.irq), 32'd0);
        step(); chk("t1_lat2", 32'(bus.irq), 32'd0);
        step(); chk("t1_lat3", 32'(bus.irq), 32'd1);
        chk("t1_id", 32'(bus.irq_id), 32'd1);
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        chk("t1_ack_irq", 32'(bus.irq), 32'd0);
        chk("t1_svc_id", 32'(bus.irq_id), 32'd1);
        bus.irq_done = 1'b1; step(); bus.irq_done = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin step(); n++; end
        chk("t1_holdoff_len", 32'(n), 32'd4);

        // 2: three simultaneous sources, ERR > RX > TX
        status_reg = 8'h00; step(); step(); step();
        control_reg = 8'h07;
        status_reg = 8'h23;
        for (int k = 0; k < 3; k++) begin
            wait_irq(n);
            if (k > 0) chk("t2_gap", 32'(n >= 4), 32'd1);
            ids[k] = int'(bus.irq_id);
            bus.irq_ack = 1'b1;  step(); bus.irq_ack = 1'b0;
            bus.irq_done = 1'b1; step(); bus.irq_done = 1'b0;
        end
        chk("t2_order0", 32'(ids[0]), 32'd3);
        chk("t2_order1", 32'(ids[1]), 32'd1);
        chk("t2_order2", 32'(ids[2]), 32'd2);
        wait_idle();

        // 3: ERR masked by dis_int, served once released
        status_reg = 8'h00; control_reg = 8'h04; dis_int = 1'b1;
        step(); step(); step();
        status_reg = 8'h04;
        for (int k = 0; k < 6; k++) step();
        chk("t3_masked", 32'(bus.irq), 32'd0);
        dis_int = 1'b0;
        wait_irq(n);
        chk("t3_id", 32'(bus.irq_id), 32'd3);
        ack_done();

        // 4: enable dropped while requesting
        status_reg = 8'h00; control_reg = 8'h01; step(); step(); step();
        status_reg = 8'h01;
        wait_irq(n);
        chk("t4_id", 32'(bus.irq_id), 32'd1);
        control_reg = 8'h00;
        step(); chk("t4_drop", 32'(bus.irq), 32'd0);
        step(); step();
        control_reg = 8'h01;
        wait_irq(n);
        chk("t4_reassert_id", 32'(bus.irq_id), 32'd1);
        ack_done();

        // 5: new RX edge lands in the ack cycle and is re-requested
        status_reg = 8'h00; step(); step(); step();
        status_reg = 8'h01;
        wait_irq(n);
        status_reg = 8'h00; step(); step();
        status_reg = 8'h01; step();
        ack_done();
        wait_irq(n);
        chk("t5_rerequest_id", 32'(bus.irq_id), 32'd1);
        ack_done();

        // 6: asynchronous reset during service
        status_reg = 8'h00; step(); step(); step();
        status_reg = 8'h01;
        wait_irq(n);
        bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
        chk("t6_in_service", 32'(bus.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_irq", 32'(bus.irq), 32'd0);
        chk("t6_async_id", 32'(bus.irq_id), 32'd0);
        chk("t6_async_busy", 32'(bus.busy), 32'd0);
        model_reset();
        step();
        reset_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) status_reg = 8'($urandom);
            if ($urandom_range(0, 31) == 0) control_reg = 8'($urandom);
            if ($urandom_range(0, 15) == 0) dis_int = ~dis_int;
            bus.irq_ack  = bus.irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            bus.irq_done = ($urandom_range(0, 5) == 0);
            step();
        end
        bus.irq_ack = 1'b0; bus.irq_done = 1'b0; dis_int = 1'b0;
        control_reg = 8'h00; status_reg = 8'h00;
        step(); step();
        ack_done();

`ifdef UART_IRQ_CNT_EN
        // Counter saturation after many RX services
        control_reg = 8'h01;
        step(); step(); step();
        for (int k = 0; k < 300; k++) begin
            status_reg = 8'h01;
            wait_irq(n);
            ack_done();
            status_reg = 8'h00;
            step(); step();
        end
        chk("cnt_rx_sat", 32'(rx_cnt), 32'(CMAX));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_irq_sequencer.md
Name: uart_irq_sequencer

Overview:
Sequences UART interrupt service toward the CPU: edge-detects the three UART interrupt conditions, latches them as pending, and presents one at a time on a single request line with an ID. A req/ack/done handshake, plus a hold-off window before the next request, prevents re-entrant service. Sits between the UART control/status registers and the processor's external interrupt input, replacing the purely combinational interrupt OR.

Parameters:
HOLDOFF_CYCLES, 4, idle cycles forced after irq_done before the next irq may assert (0 = none)
CNT_W, 8, width of the optional per-source service counters

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
control_reg  input  8  UART control register; [0] rxIntEn, [1] txIntEn, [2] errIntEn
status_reg  input  8  UART status register; [0] rxBRFull, [1] oErr, [2] pErr, [3] fErr, [5] txBREmpty
dis_int  input  1  suppresses arbitration of the error source while high
irq_ack  input  1  CPU accepts the current request (single-cycle pulse)
irq_done  input  1  CPU end-of-service (single-cycle pulse)
irq  output  1  interrupt request to CPU
irq_id  output  2  0 none, 1 RX, 2 TX, 3 ERR; valid while irq=1 and held through SERVICE
busy  output  1  high in ASSERT, SERVICE, HOLDOFF
rx_cnt, tx_cnt, err_cnt  output  CNT_W each  only with UART_IRQ_CNT_EN

Behaviour:
- Reset: irq=0, irq_id=0, busy=0, pending=000, edge-detect registers=0, state IDLE, hold-off counter 0, counters 0.
- Conditions: rx_c=rxBRFull; tx_c=txBREmpty; err_c=oErr|pErr|fErr. Each is registered once; a rising edge (c & ~c_q) sets its pending bit. Edge detection runs in every state.
- Eligible = pending & enable; the ERR bit also requires ~dis_int. Ineligible pending bits are retained, not cleared.
- Priority: ERR > RX > TX.
- FSM:
  - IDLE: if any eligible bit is set, go to ASSERT next cycle and latch irq_id to the highest-priority eligible source.
  - ASSERT: irq=1. On irq_ack, clear that source's pending bit and go to SERVICE; irq=0 from the next cycle. If the source becomes ineligible before ack (enable dropped or dis_int set), return to IDLE with irq=0 and the pending bit kept.
  - SERVICE: irq=0, irq_id held. On irq_done, go to HOLDOFF with the counter loaded to HOLDOFF_CYCLES; with HOLDOFF_CYCLES=0, go straight to IDLE.
  - HOLDOFF: decrement the counter each cycle; at 1, go to IDLE; irq_id returns to 0.
- Latency: condition rising edge to irq=1 is 3 cycles from IDLE (register, pending set, ASSERT).
- Simultaneous set and clear of the same pending bit (new edge in the ack cycle): set wins, and the source is re-requested later.
- irq_ack outside ASSERT and irq_done outside SERVICE are ignored.
- Higher-priority arrivals during ASSERT do not change irq_id; they are served next.
- reset_n low mid-operation aborts any state immediately to reset values.

Optional Feature:
UART_IRQ_CNT_EN
- Defined: rx_cnt/tx_cnt/err_cnt increment on each irq_ack for their source and saturate at all-ones.
- Undefined: the ports and logic are absent.

Decomposition:
- Package uart_irq_pkg:
  - typedef enum irq_id_t {IRQ_NONE=0, IRQ_RX=1, IRQ_TX=2, IRQ_ERR=3}
  - typedef enum state_t {IDLE, ASSERT, SERVICE, HOLDOFF}
  - bit-index constants for control_reg/status_reg fields
- One natural sub-module, uart_irq_pend: edge detect plus pending latch for one source, instantiated three times.

Test Plan:
1. control_reg=0x01, pulse rxBRFull 0→1 → irq=1 three cycles later with irq_id=1; ack → irq=0; done → busy low after 4 hold-off cycles.
2. control_reg=0x07, rxBRFull, txBREmpty and oErr rise in the same cycle → service order irq_id 3, 1, 2, each separated by ≥4 idle cycles.
3. control_reg=0x04, dis_int=1, pErr rises → no irq; drop dis_int → irq=1 with irq_id=3.
4. In ASSERT with irq_id=1, clear control_reg[0] before ack → irq drops next cycle; set control_reg[0] again → irq re-asserts with irq_id=1.
5. New rxBRFull edge timed so its pending set coincides with the RX ack cycle → after done and hold-off, a second RX request appears.
6. reset_n low during SERVICE → all outputs 0 asynchronously; with UART_IRQ_CNT_EN, 300 RX services → rx_cnt=255.
